// File: rtl/ctrl_flush_pipe.sv
// ctrl_flush_pipe
//   ID/EX control-bundle pipeline register with flush, stall and
//   multi-cycle bubble insertion. A flush request squashes FLUSH_CYCLES
//   consecutive slots (restarting while flush stays high). Bubbles keep
//   only the KEEP_MASK bits of ctrl_in and carry valid_out=0. Every
//   inserted bubble bumps a saturating performance counter.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   ctrl_in     in   [CTRL_W-1:0] decoded control bundle from ID
//   valid_in    in   ID stage holds a real instruction
//   stall       in   hold the register (load-use hazard)
//   flush       in   squash request (pulse or level)
//   ctrl_out    out  [CTRL_W-1:0] registered control bundle to EX
//   valid_out   out  ctrl_out carries a real instruction
//   flushing    out  multi-cycle flush in progress
//   bubble_cnt  out  [CNT_W-1:0] saturating bubble count
module ctrl_flush_pipe #(
  parameter int               CTRL_W       = 10,
  parameter int               FLUSH_CYCLES = 1,
  parameter logic [CTRL_W-1:0] KEEP_MASK   = '0,
  parameter int               CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              flushing,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // The remaining-bubble counter is 4 bits wide, so 15 is the ceiling.
  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_cfg
      $error("ctrl_flush_pipe: FLUSH_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] RELOAD   = 4'(FLUSH_CYCLES - 1);
  localparam bit         MULTI    = (FLUSH_CYCLES > 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state, state_d;
  logic [3:0]  rem, rem_d;
  logic        load_bubble;
  logic        load_input;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 4'd0;
    end else begin
      state <= state_d;
      rem   <= rem_d;
    end
  end

  // Next-state logic: flush beats stall in both states.
  always_comb begin
    state_d = state;
    rem_d   = rem;
    unique case (state)
      IDLE: begin
        if (flush && MULTI) begin
          state_d = FLUSH;
          rem_d   = RELOAD;
        end
      end
      FLUSH: begin
        if (flush) begin
          rem_d = RELOAD;
        end else if (!stall) begin
          rem_d = rem - 4'd1;
          if (rem == 4'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 4'd0;
      end
    endcase
  end

  // Output decode: which update the EX-side register takes this edge.
  always_comb begin
    load_bubble = 1'b0;
    load_input  = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          load_bubble = 1'b1;
        end else if (!stall) begin
          load_input = 1'b1;
        end
      end
      FLUSH: begin
        // A stalled FLUSH slot holds: no bubble, no count.
        load_bubble = flush || !stall;
      end
      default: begin
        load_bubble = 1'b0;
        load_input  = 1'b0;
      end
    endcase
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_out   <= '0;
      valid_out  <= 1'b0;
      bubble_cnt <= '0;
    end else if (load_bubble) begin
      ctrl_out   <= ctrl_in & KEEP_MASK;
      valid_out  <= 1'b0;
      bubble_cnt <= sat_inc(bubble_cnt);
    end else if (load_input) begin
      ctrl_out   <= ctrl_in;
      valid_out  <= valid_in;
    end
  end

  // Driven straight from the state register, so no input-to-output path.
  assign flushing = (state == FLUSH);

endmodule

// File: tb/tb_ctrl_flush_pipe.sv
module tb_ctrl_flush_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Three configurations: A (FC=1), B (FC=3, keep bit0), C (FC=4, 4-bit counter)
  logic [9:0]  ci [3];
  logic        vi [3];
  logic        st [3];
  logic        fl [3];
  logic [9:0]  co [3];
  logic        vo [3];
  logic        fo [3];
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  ctrl_flush_pipe #(.CTRL_W(10), .FLUSH_CYCLES(1), .KEEP_MASK(10'h000), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ci[0]), .valid_in(vi[0]), .stall(st[0]),
    .flush(fl[0]), .ctrl_out(co[0]), .valid_out(vo[0]), .flushing(fo[0]), .bubble_cnt(cnt_a));

  ctrl_flush_pipe #(.CTRL_W(10), .FLUSH_CYCLES(3), .KEEP_MASK(10'h001), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ci[1]), .valid_in(vi[1]), .stall(st[1]),
    .flush(fl[1]), .ctrl_out(co[1]), .valid_out(vo[1]), .flushing(fo[1]), .bubble_cnt(cnt_b));

  ctrl_flush_pipe #(.CTRL_W(10), .FLUSH_CYCLES(4), .KEEP_MASK(10'h000), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ci[2]), .valid_in(vi[2]), .stall(st[2]),
    .flush(fl[2]), .ctrl_out(co[2]), .valid_out(vo[2]), .flushing(fo[2]), .bubble_cnt(cnt_c));

  typedef struct {
    int          inst;
    string       name;
    logic [9:0]  ctrl;
    logic        vld;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [28:0] observed(input int inst);
    logic [15:0] c;
    case (inst)
      0:       c = cnt_a;
      1:       c = cnt_b;
      default: c = {12'd0, cnt_c};
    endcase
    return {co[inst], vo[inst], fo[inst], c};
  endfunction

  task automatic compare(input string name, input int inst, input logic [28:0] req);
    logic [28:0] act;
    act = observed(inst);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got ctrl=%h vld=%b fl=%b cnt=%0d, want ctrl=%h vld=%b fl=%b cnt=%0d",
               name, act[28:19], act[18], act[17], act[15:0],
               req[28:19], req[18], req[17], req[15:0]);
    end
  endtask

  // Monitor: every edge presents a new output; compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e.name, e.inst, {e.ctrl, e.vld, e.fl, e.cnt});
      end
    end
  end

  task automatic step(input int inst, input string name,
                      input logic [9:0] c, input logic v, input logic s, input logic f,
                      input logic [9:0] ec, input logic ev, input logic ef, input int ecnt);
    exp_t e;
    @(negedge clk);
    ci[inst] = c; vi[inst] = v; st[inst] = s; fl[inst] = f;
    e.inst = inst; e.name = name; e.ctrl = ec; e.vld = ev; e.fl = ef; e.cnt = 16'(ecnt);
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ci[i] = '0; vi[i] = 1'b0; st[i] = 1'b1; fl[i] = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset(input int inst, input string name);
    drain();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    compare(name, inst, 29'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();

    // ---- Config A: FLUSH_CYCLES=1, no keep mask
    do_reset(0, "a_reset");
    step(0, "a_run",      10'h2A5, 1, 0, 0, 10'h2A5, 1, 0, 0);
    step(0, "a_flush",    10'h3FF, 1, 0, 1, 10'h000, 0, 0, 1);
    step(0, "a_after",    10'h155, 1, 0, 0, 10'h155, 1, 0, 1);
    step(0, "a_stall",    10'h0AA, 1, 1, 0, 10'h155, 1, 0, 1);
    step(0, "a_invalid",  10'h0AA, 0, 0, 0, 10'h0AA, 0, 0, 1);
    step(0, "a_lvl1",     10'h3FF, 1, 0, 1, 10'h000, 0, 0, 2);
    step(0, "a_lvl2",     10'h3FF, 1, 0, 1, 10'h000, 0, 0, 3);
    step(0, "a_resume",   10'h123, 1, 0, 0, 10'h123, 1, 0, 3);

    // ---- Config B: FLUSH_CYCLES=3, KEEP_MASK=10'h001
    do_reset(1, "b_reset");
    step(1, "b_flush_stall", 10'h3FF, 1, 1, 1, 10'h001, 0, 1, 1);
    step(1, "b_keep0",       10'h3FE, 1, 0, 0, 10'h000, 0, 1, 2);
    step(1, "b_keep1",       10'h3FF, 1, 0, 0, 10'h001, 0, 0, 3);
    step(1, "b_accept",      10'h2A5, 1, 0, 0, 10'h2A5, 1, 0, 3);
    step(1, "b_e0",          10'h111, 1, 0, 1, 10'h001, 0, 1, 4);
    step(1, "b_e1_held",     10'h222, 1, 1, 0, 10'h001, 0, 1, 4);
    step(1, "b_e2",          10'h222, 1, 0, 0, 10'h000, 0, 1, 5);
    step(1, "b_e3",          10'h333, 1, 0, 0, 10'h001, 0, 0, 6);
    step(1, "b_e4_accept",   10'h0F0, 1, 0, 0, 10'h0F0, 1, 0, 6);

    // ---- Config C: FLUSH_CYCLES=4, 4-bit counter
    do_reset(2, "c_reset");
    step(2, "c_run",      10'h2A5, 1, 0, 0, 10'h2A5, 1, 0, 0);
    step(2, "c_e0",       10'h100, 1, 0, 1, 10'h000, 0, 1, 1);
    step(2, "c_e1",       10'h101, 1, 0, 0, 10'h000, 0, 1, 2);
    step(2, "c_e2_restart", 10'h102, 1, 0, 1, 10'h000, 0, 1, 3);
    step(2, "c_e3",       10'h103, 1, 0, 0, 10'h000, 0, 1, 4);
    drain();
    // Asynchronous reset between edges 3 and 4, checked before any edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("c_midflush_reset", 2, 29'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2, "c_no_residual", 10'h1C3, 1, 0, 0, 10'h1C3, 1, 0, 0);
    step(2, "c_invalid",     10'h1C4, 0, 0, 0, 10'h1C4, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(2, $sformatf("c_sat%0d", i), 10'h3FF, 1, 0, 1, 10'h000, 0, 1, (i + 1 > 15) ? 15 : i + 1);
    end
    step(2, "c_tail0",  10'h3FF, 1, 0, 0, 10'h000, 0, 1, 15);
    step(2, "c_tail1",  10'h3FF, 1, 0, 0, 10'h000, 0, 1, 15);
    step(2, "c_tail2",  10'h3FF, 1, 0, 0, 10'h000, 0, 0, 15);
    step(2, "c_accept", 10'h2A5, 1, 0, 0, 10'h2A5, 1, 0, 15);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_flush_pipe.md
Name: ctrl_flush_pipe

Overview:
- Parametrised ID/EX control-bundle pipeline register with flush, stall and multi-cycle bubble insertion.
- Sits between the decoder/control unit and the EX stage.
- Squashes up to FLUSH_CYCLES consecutive instructions after a taken branch or jump.
- KEEP_MASK selects control bits that pass through a flush unchanged; all other bits are cleared.
- Counts inserted bubbles for performance monitoring.

Parameters:
- CTRL_W, 10, width of the control bundle {alusrc, alufunc[3:0], regdest, readdmem, writedmem, regwrite, memtoreg}.
- FLUSH_CYCLES, 1, number of consecutive bubbles inserted per flush request. Legal range is 1 to 15.
- KEEP_MASK, {CTRL_W{1'b0}}, bits set to 1 keep their ctrl_in value in a bubble. All other bits are forced to 0.
- CNT_W, 16, width of the bubble_cnt performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_in  in  CTRL_W  decoded control bundle from the ID stage.
- valid_in  in  1  ID stage holds a real instruction.
- stall  in  1  hold the pipeline register (load-use hazard).
- flush  in  1  squash request (branch taken), single-cycle pulse or level.
- ctrl_out  out  CTRL_W  registered control bundle to the EX stage.
- valid_out  out  1  ctrl_out carries a real instruction.
- flushing  out  1  multi-cycle flush in progress (state FLUSH).
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ctrl_out=0, valid_out=0, flushing=0, bubble_cnt=0.
  - State IDLE, rem=0.
  - Deassertion is synchronised externally. The block needs no other reset handling.
- Bubble value: ctrl_in & KEEP_MASK, with valid=0.
- "Load bubble" means ctrl_out <= bubble value, valid_out <= 0, bubble_cnt <= bubble_cnt+1, saturating at all-ones.
- rem is an internal 4-bit down-counter.
- State IDLE:
  - flush=1 (regardless of stall): load bubble. If FLUSH_CYCLES>1, set rem <= FLUSH_CYCLES-1 and go to FLUSH. Otherwise stay in IDLE.
  - flush=0, stall=1: hold ctrl_out, valid_out and bubble_cnt.
  - flush=0, stall=0: ctrl_out <= ctrl_in, valid_out <= valid_in.
- State FLUSH:
  - flush=1: load bubble, rem <= FLUSH_CYCLES-1 (restart), stay in FLUSH.
  - flush=0, stall=1: hold everything, including rem. No bubble is counted.
  - flush=0, stall=0: load bubble, rem <= rem-1. If rem==1, go to IDLE.
- flushing is 1 exactly when state==FLUSH. It is a registered output with no combinational path from inputs.
- Priority: reset > flush > stall > normal load.
- Latency: ctrl_in reaches ctrl_out one edge after acceptance.
  - Flush with no stall yields exactly FLUSH_CYCLES consecutive bubbles, then ctrl_in is accepted on the next edge.
- A flush held high for N cycles restarts the counter each cycle, giving N+FLUSH_CYCLES-1 bubbles in total.
- bubble_cnt saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Reset asserted mid-FLUSH forces IDLE immediately. No residual bubbles are inserted after release.
- FLUSH_CYCLES outside 1..15 is a configuration error, flagged by an elaboration-time check.

Test Plan:
- Reset then run: after rst_n 0→1, drive ctrl_in=10'h2A5, valid_in=1 for one edge → ctrl_out=10'h2A5, valid_out=1, bubble_cnt=0.
- Single flush: FLUSH_CYCLES=1, KEEP_MASK=0, flush pulse with ctrl_in=10'h3FF → next edge ctrl_out=0, valid_out=0, flushing=0, bubble_cnt=1. The following edge loads ctrl_in.
- Multi-cycle flush with stall: FLUSH_CYCLES=3, flush pulse at edge 0, stall=1 at edge 1, stall=0 afterwards → bubbles at edges 0, 1(held), 2, 3; flushing high after edges 0 through 2; ctrl_in accepted at edge 4; bubble_cnt=3.
- Keep mask and simultaneous events: KEEP_MASK=10'h001, flush=1 and stall=1 together, ctrl_in=10'h3FF → ctrl_out=10'h001, valid_out=0 (flush wins over stall).
- Restart and reset mid-flush: FLUSH_CYCLES=4, flush pulse at edge 0, second flush at edge 2 → flushing stays high through edge 4. Then assert rst_n=0 between edges 3 and 4 → ctrl_out=0, flushing=0 and bubble_cnt=0 immediately; no bubbles after release.
- Saturation: CNT_W=4, hold flush=1 for 20 cycles → bubble_cnt reaches 4'hF and stays there.
